// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch/MOV resolution sequencer. Offers one taken-branch redirect
// to IF over valid/ready, emits link/mov write pulses and keeps saturating branch statistics.
//
// state  | meaning
// S_IDLE | nothing held; a request with ready operands resolves in the same cycle
// S_WAIT | branch/MOV held in ID until forwarded operands become valid
// S_HOLD | taken-branch redirect offered to IF until accepted
module branch_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_mov,
    input  logic             id_is_link,
    input  logic             id_uses_rt,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      pc_id,
    input  logic [15:0]      imm16,
    input  logic             cmp,
    input  logic             if_ready,
    output logic             stall_id,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             link_we,
    output logic             mov_we,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_redir_valid;
    logic [31:0]         r_redir_pc;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_cnt_branch;
    logic [CNT_W-1:0]    r_cnt_taken;
    logic [CNT_W-1:0]    r_cnt_stall;

    logic                w_active;
    logic                w_req;
    logic                w_ops_ok;
    logic                w_resolve;
    logic                w_br_resolve;
    logic                w_taken;
    logic                w_stall;
    logic                w_in_hold;
    logic [31:0]         w_target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_active     = ~reset & ~flush;
    assign w_in_hold    = (r_state == S_HOLD);
    assign w_req        = id_valid & (id_is_branch | id_is_mov);
    assign w_ops_ok     = rs_ready & (rt_ready | ~id_uses_rt);
    assign w_target     = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

    // Resolution happens combinationally in IDLE or WAIT; HOLD ignores ID entirely.
    assign w_resolve    = w_active & w_req & w_ops_ok & ~w_in_hold;
    assign w_br_resolve = w_resolve & id_is_branch;
    assign w_taken      = w_br_resolve & cmp;
    assign w_stall      = w_active & ((~w_in_hold & w_req & ~w_ops_ok) |
                                      (w_in_hold & ~if_ready));

    assign stall_id     = w_stall;
    assign redir_valid  = r_redir_valid & w_active;
    assign redir_pc     = r_redir_pc;
    assign link_we      = w_br_resolve & id_is_link;
    assign mov_we       = w_resolve & ~id_is_branch & cmp;
    assign wait_timeout = w_active & (r_state == S_WAIT) &
                          (r_wait_cnt == WCNT_W'(MAX_WAIT));
    assign cnt_branch   = r_cnt_branch;
    assign cnt_taken    = r_cnt_taken;
    assign cnt_stall    = r_cnt_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_wait_cnt    <= '0;
            r_cnt_branch  <= '0;
            r_cnt_taken   <= '0;
            r_cnt_stall   <= '0;
        end else begin
            if (w_stall) begin
                r_cnt_stall <= sat_inc(r_cnt_stall);
            end
            if (w_br_resolve) begin
                r_cnt_branch <= sat_inc(r_cnt_branch);
            end
            if (w_taken) begin
                r_cnt_taken <= sat_inc(r_cnt_taken);
            end

            if (flush) begin
                r_state       <= S_IDLE;
                r_redir_valid <= 1'b0;
                r_wait_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT: begin
                        if (w_resolve) begin
                            r_wait_cnt <= '0;
                            if (w_taken) begin
                                r_state       <= S_HOLD;
                                r_redir_valid <= 1'b1;
                                r_redir_pc    <= w_target;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_req) begin
                            r_state <= S_WAIT;
                            // The IDLE cycle that first stalled counts as one wait cycle.
                            if (r_state == S_IDLE) begin
                                r_wait_cnt <= WCNT_W'(1);
                            end else if (r_wait_cnt <= WCNT_W'(MAX_WAIT)) begin
                                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                            end
                        end else begin
                            r_state    <= S_IDLE;
                            r_wait_cnt <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (if_ready) begin
                            r_state       <= S_IDLE;
                            r_redir_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_redir_valid <= 1'b0;
                        r_wait_cnt    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a transaction driver predicts events into queues, a monitor
// pops them as the DUT emits pulses/redirects; counters checked against arithmetic totals.
module tb_branch_ctrl;
    localparam int MAX_WAIT = 7;

    logic clk = 1'b0;
    logic reset, flush, id_valid, id_is_branch, id_is_mov, id_is_link, id_uses_rt;
    logic rs_ready, rt_ready, cmp, if_ready;
    logic [31:0] pc_id;
    logic [15:0] imm16;

    logic stall_id, redir_valid, link_we, mov_we, wait_timeout;
    logic [31:0] redir_pc;
    logic [15:0] cnt_branch, cnt_taken, cnt_stall;

    logic s_stall_id, s_redir_valid, s_link_we, s_mov_we, s_wait_timeout;
    logic [31:0] s_redir_pc;
    logic [1:0] s_cnt_branch, s_cnt_taken, s_cnt_stall;

    branch_ctrl #(.CNT_W(16), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_is_branch(id_is_branch), .id_is_mov(id_is_mov), .id_is_link(id_is_link),
        .id_uses_rt(id_uses_rt), .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_id(pc_id),
        .imm16(imm16), .cmp(cmp), .if_ready(if_ready), .stall_id(stall_id),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .link_we(link_we), .mov_we(mov_we),
        .wait_timeout(wait_timeout), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
        .cnt_stall(cnt_stall));

    branch_ctrl #(.CNT_W(2), .MAX_WAIT(MAX_WAIT)) u_small (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_is_branch(id_is_branch), .id_is_mov(id_is_mov), .id_is_link(id_is_link),
        .id_uses_rt(id_uses_rt), .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_id(pc_id),
        .imm16(imm16), .cmp(cmp), .if_ready(if_ready), .stall_id(s_stall_id),
        .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .link_we(s_link_we), .mov_we(s_mov_we),
        .wait_timeout(s_wait_timeout), .cnt_branch(s_cnt_branch), .cnt_taken(s_cnt_taken),
        .cnt_stall(s_cnt_stall));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    logic [31:0] q_redir[$];
    logic [31:0] q_link[$];
    logic [31:0] q_mov[$];
    logic [31:0] q_tmo[$];
    int m_branch = 0;
    int m_taken = 0;
    int m_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: pulse seen with no expected event (pc_id %h)", name, pc_id);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Monitor: every emitted event must match the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (link_we) begin
                    if (q_link.size() == 0) unexpected("link_we");
                    else chk("link_pc", pc_id, q_link.pop_front());
                end
                if (mov_we) begin
                    if (q_mov.size() == 0) unexpected("mov_we");
                    else chk("mov_pc", pc_id, q_mov.pop_front());
                end
                if (wait_timeout) begin
                    if (q_tmo.size() == 0) unexpected("wait_timeout");
                    else chk("timeout_pc", pc_id, q_tmo.pop_front());
                end
                if (redir_valid && if_ready) begin
                    if (q_redir.size() == 0) unexpected("redirect");
                    else chk("redir_accept_pc", redir_pc, q_redir.pop_front());
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input bit exp_stall, input bit exp_rv, input logic [31:0] exp_pc);
        @(negedge clk);
        chk("stall_id", 32'(stall_id), 32'(exp_stall));
        chk("redir_valid", 32'(redir_valid), 32'(exp_rv));
        if (exp_rv) chk("redir_pc", redir_pc, exp_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt();
        chk("cnt_branch", 32'(cnt_branch), 32'(sat(m_branch, 16)));
        chk("cnt_taken", 32'(cnt_taken), 32'(sat(m_taken, 16)));
        chk("cnt_stall", 32'(cnt_stall), 32'(sat(m_stall, 16)));
        chk("small_cnt_branch", 32'(s_cnt_branch), 32'(sat(m_branch, 2)));
        chk("small_cnt_taken", 32'(s_cnt_taken), 32'(sat(m_taken, 2)));
        chk("small_cnt_stall", 32'(s_cnt_stall), 32'(sat(m_stall, 2)));
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_is_branch = 1'b0; id_is_mov = 1'b0; id_is_link = 1'b0;
        id_uses_rt = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0; cmp = 1'b0;
        if_ready = 1'b0; flush = 1'b0;
    endtask

    // kind: 0 no request, 1 branch, 2 MOV. w = operand-wait cycles, c = final COMP result,
    // r = cycles IF refuses the redirect, f: 0 none, 1 flush last wait cycle, 2 flush at resolve,
    // 3 flush in HOLD after r refused cycles.
    task automatic run_instr(input int kind, input bit link, input bit urt, input bit both,
                             input logic [31:0] pc, input logic [15:0] imm, input int w,
                             input bit c, input int r, input int f);
        logic [31:0] tgt;
        int off;
        bit aborted;
        off = int'($signed(imm)) * 4;
        tgt = pc + 32'd4 + 32'(off);
        aborted = 1'b0;
        if (kind == 0) begin
            id_valid = 1'($urandom);
            id_is_branch = id_valid ? 1'b0 : 1'($urandom);
            id_is_mov = id_valid ? 1'b0 : 1'($urandom);
            id_is_link = 1'($urandom); id_uses_rt = 1'($urandom);
            rs_ready = 1'($urandom); rt_ready = 1'($urandom); cmp = 1'($urandom);
            if_ready = 1'($urandom); pc_id = pc; imm16 = imm;
            cyc(1'b0, 1'b0, 32'd0);
            return;
        end
        id_valid = 1'b1;
        id_is_branch = (kind == 1);
        id_is_mov = (kind == 2) || both;
        id_is_link = (kind == 1) && link;
        id_uses_rt = urt;
        pc_id = pc; imm16 = imm;
        for (int j = 1; j <= w; j++) begin
            if_ready = 1'($urandom);
            cmp = 1'($urandom);
            if (f == 1 && j == w) begin
                rs_ready = 1'b1; rt_ready = 1'b1; flush = 1'b1;
                cyc(1'b0, 1'b0, 32'd0);
                flush = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (urt) begin
                case ($urandom_range(0, 2))
                    0: begin rs_ready = 1'b0; rt_ready = 1'b1; end
                    1: begin rs_ready = 1'b1; rt_ready = 1'b0; end
                    default: begin rs_ready = 1'b0; rt_ready = 1'b0; end
                endcase
            end else begin
                rs_ready = 1'b0; rt_ready = 1'($urandom);
            end
            m_stall++;
            if (j == MAX_WAIT + 1) q_tmo.push_back(pc);
            cyc(1'b1, 1'b0, 32'd0);
        end
        if (!aborted) begin
            rs_ready = 1'b1;
            rt_ready = urt ? 1'b1 : 1'($urandom);
            cmp = c;
            if_ready = 1'($urandom);
            if (f == 2) begin
                flush = 1'b1;
                cyc(1'b0, 1'b0, 32'd0);
                flush = 1'b0;
                aborted = 1'b1;
            end else begin
                if (w + 1 == MAX_WAIT + 1) q_tmo.push_back(pc);
                if (kind == 1) begin
                    m_branch++;
                    if (c) m_taken++;
                    if (link) q_link.push_back(pc);
                end else if (c) begin
                    q_mov.push_back(pc);
                end
                cyc(1'b0, 1'b0, 32'd0);
            end
        end
        if (!aborted && kind == 1 && c) begin
            id_valid = 1'b0; cmp = 1'($urandom);
            rs_ready = 1'($urandom); rt_ready = 1'($urandom);
            for (int k = 0; k < r; k++) begin
                if_ready = 1'b0;
                m_stall++;
                cyc(1'b1, 1'b1, tgt);
            end
            if_ready = 1'b1;
            if (f == 3) begin
                flush = 1'b1;
                cyc(1'b0, 1'b0, 32'd0);
                flush = 1'b0;
            end else begin
                q_redir.push_back(tgt);
                cyc(1'b0, 1'b1, tgt);
            end
        end
        idle_inputs();
        if_ready = 1'($urandom);
        cyc(1'b0, 1'b0, 32'd0);
        chk_cnt();
    endtask

    initial begin
        int kind, sel, w, r, f;
        bit urt, link, both, c;
        logic [31:0] pc;

        idle_inputs();
        pc_id = 32'd0; imm16 = 16'd0;
        reset = 1'b1;
        id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rt = 1'b1; cmp = 1'b1;
        @(negedge clk);
        chk("rst_stall_id", 32'(stall_id), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_pulses", {29'd0, link_we, mov_we, wait_timeout}, 32'd0);
        chk_cnt();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, 32'd0);

        // Directed cases
        run_instr(1, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 16'h0004, 0, 1'b1, 0, 0);
        run_instr(1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 16'h0010, 3, 1'b0, 0, 0);
        chk("bne_cnt_stall", 32'(cnt_stall), 32'd3);
        run_instr(1, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 16'h0020, 0, 1'b0, 0, 0);
        run_instr(1, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 16'hFFFF, 0, 1'b1, 2, 0);
        run_instr(1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 16'h8000, 0, 1'b1, 1, 3);
        run_instr(2, 1'b0, 1'b1, 1'b0, 32'h0000_7000, 16'h0000, 0, 1'b1, 0, 0);
        run_instr(1, 1'b0, 1'b1, 1'b0, 32'h0000_8000, 16'h0001, 9, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++)
            run_instr(1, 1'b0, 1'b0, 1'b0, 32'h0000_9000 + 32'(i * 16), 16'h0002, 0, 1'b1, 0, 0);
        chk("small_taken_sat", 32'(s_cnt_taken), 32'd3);

        // Randomised transactions
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            kind = (sel < 2) ? 0 : ((sel < 7) ? 1 : 2);
            if (kind == 1) begin
                urt = 1'($urandom);
                link = urt ? 1'b0 : 1'($urandom);
                both = ($urandom_range(0, 15) == 0);
            end else begin
                urt = 1'b1; link = 1'b0; both = 1'b0;
            end
            w = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
            c = 1'($urandom);
            r = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            f = 0;
            if (sel == 0 && w > 0) f = 1;
            else if (sel == 1) f = 2;
            else if (sel == 2 && kind == 1 && c && r > 0) f = 3;
            pc = $urandom & 32'hFFFF_FFFC;
            run_instr(kind, link, urt, both, pc, 16'($urandom), w, c, r, f);
        end

        // Reset while a redirect is pending
        id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rt = 1'b0; rs_ready = 1'b1;
        cmp = 1'b1; pc_id = 32'h0000_0100; imm16 = 16'h0001;
        m_branch++; m_taken++;
        cyc(1'b0, 1'b0, 32'd0);
        idle_inputs();
        m_stall++;
        cyc(1'b1, 1'b1, 32'h0000_0108);
        reset = 1'b1;
        #2;
        chk("hold_rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("hold_rst_redir_pc", redir_pc, 32'd0);
        chk("hold_rst_stall", 32'(stall_id), 32'd0);
        m_branch = 0; m_taken = 0; m_stall = 0;
        chk_cnt();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

        // Reset while waiting for operands
        id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rt = 1'b1; rs_ready = 1'b1;
        rt_ready = 1'b0; pc_id = 32'h0000_0200;
        m_stall += 2;
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        chk("wait_cnt_stall", 32'(cnt_stall), 32'(sat(m_stall, 16)));
        reset = 1'b1;
        #2;
        chk("wait_rst_stall", 32'(stall_id), 32'd0);
        m_stall = 0;
        chk_cnt();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rt_ready = 1'b1; cmp = 1'b0;
        m_branch++;
        cyc(1'b0, 1'b0, 32'd0);
        idle_inputs();
        cyc(1'b0, 1'b0, 32'd0);
        chk_cnt();

        mon_en = 1'b0;
        chk("redir_q_left", 32'(q_redir.size()), 32'd0);
        chk("link_q_left", 32'(q_link.size()), 32'd0);
        chk("mov_q_left", 32'(q_mov.size()), 32'd0);
        chk("tmo_q_left", 32'(q_tmo.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
